// File: rtl/accel_pkg.sv
// Shared types and constants for the partial-sum requantization / writeback path.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int QMAX   = 127;
  localparam int QMIN   = -128;
  localparam int LANE_W = 8;
  localparam int WORD_W = 32;

endpackage

// File: rtl/requant_lane.sv
// One output lane: round, arithmetic shift, optional ReLU, saturate to int8 (registered).
module requant_lane
  import accel_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ACC_WIDTH-1:0]   i_psum,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic                   i_relu_en,
  output logic [LANE_W-1:0]      o_q,
  output logic                   o_sat
);

  // One extra bit so the rounding add cannot wrap.
  logic signed [ACC_WIDTH:0] rnd;
  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] r;
  logic [LANE_W-1:0]         q_d, q_q;
  logic                      sat_d, sat_q;

  always_comb begin
    rnd = '0;
    if (i_shift != '0) begin
      rnd = (ACC_WIDTH+1)'(1) << (i_shift - 1'b1);
    end
    sum   = $signed({i_psum[ACC_WIDTH-1], i_psum}) + rnd;
    r     = sum >>> i_shift;
    q_d   = r[LANE_W-1:0];
    sat_d = 1'b0;
    if (i_relu_en && r[ACC_WIDTH]) begin
      q_d = '0;
    end else if (r > (ACC_WIDTH+1)'(QMAX)) begin
      q_d   = LANE_W'(QMAX);
      sat_d = 1'b1;
    end else if (r < (ACC_WIDTH+1)'(QMIN)) begin
      q_d   = LANE_W'(QMIN);
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      sat_q <= sat_d;
    end
  end

  assign o_q   = q_q;
  assign o_sat = sat_q;

endmodule

// File: rtl/psum_requant_writeback.sv
// Deskews PE-array column sums, requantizes to int8, packs and writes to SRAM through a small FIFO.
// Optional saturation statistics counter enabled by defining REQUANT_STATS_EN.
module psum_requant_writeback
  import accel_pkg::*;
#(
  parameter int ACC_WIDTH   = 32,
  parameter int COLS        = 4,
  parameter int OUT_WIDTH   = LANE_W,
  parameter int ADDR_WIDTH  = 10,
  parameter int SHIFT_WIDTH = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [ADDR_WIDTH-1:0]     i_base_addr,
  input  logic [15:0]               i_num_vectors,
  input  logic [SHIFT_WIDTH-1:0]    i_shift,
  input  logic                      i_relu_en,
  input  logic                      i_valid,
  input  logic [COLS*ACC_WIDTH-1:0] i_psum_flat,
  input  logic                      i_sram_ready,
  output logic                      o_sram_we,
  output logic [ADDR_WIDTH-1:0]     o_sram_addr,
  output logic [COLS*OUT_WIDTH-1:0] o_sram_wdata,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_overflow,
  output logic [15:0]               o_sat_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WORD  = COLS * OUT_WIDTH;
  localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d, idx_q, idx_d;
  logic [15:0]             num_q, num_d, pushed_q, pushed_d;
  logic [SHIFT_WIDTH-1:0]  shift_q, shift_d;
  logic                    relu_q, relu_d, ovf_q, ovf_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic [COLS-2:0]         vld_pipe_q, vld_pipe_d;
  logic                    rq_vld_q, rq_vld_d;
  logic [WORD-1:0]         fifo_q [FIFO_DEPTH];
  logic [WORD-1:0]         fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]          cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]    aligned [COLS];
  logic [WORD-1:0]         rq_word;
  logic [COLS-1:0]         rq_sat;
  logic                    in_valid, start_ok, take, push, pop;

  // Column c arrives c cycles late; delay it so all columns line up with column COLS-1.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign aligned[c] = i_psum_flat[c*ACC_WIDTH +: ACC_WIDTH];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] dly_q [D];
      logic [ACC_WIDTH-1:0] dly_d [D];
      always_comb begin
        dly_d[0] = i_psum_flat[c*ACC_WIDTH +: ACC_WIDTH];
        for (int k = 1; k < D; k++) dly_d[k] = dly_q[k-1];
      end
      always_ff @(posedge clk) begin
        for (int k = 0; k < D; k++) begin
          if (rst) dly_q[k] <= '0;
          else     dly_q[k] <= dly_d[k];
        end
      end
      assign aligned[c] = dly_q[D-1];
    end

    requant_lane #(
      .ACC_WIDTH  (ACC_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_psum   (aligned[c]),
      .i_shift  (shift_q),
      .i_relu_en(relu_q),
      .o_q      (rq_word[c*OUT_WIDTH +: OUT_WIDTH]),
      .o_sat    (rq_sat[c])
    );
  end

  always_comb begin
    start_ok   = i_start && (state_q == IDLE || state_q == DONE);
    in_valid   = i_valid && (state_q == RUN);
    vld_pipe_d = {vld_pipe_q[COLS-3:0], in_valid};
    rq_vld_d   = vld_pipe_q[COLS-2];
    pop        = (cnt_q != '0) && (state_q != IDLE) && i_sram_ready;
    take       = rq_vld_q && (state_q == RUN) && (pushed_q != num_q);
    // A full FIFO still accepts when the head leaves in the same cycle.
    push       = take && ((cnt_q != FIFO_FULL) || pop);

    state_d  = state_q;
    base_d   = base_q;
    num_d    = num_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    ovf_d    = ovf_q;
    pushed_d = pushed_q;
    idx_d    = idx_q;
    fifo_d   = fifo_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;

    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      idx_d  = idx_q + 1'b1;
    end
    if (push) begin
      fifo_d[wptr_q] = rq_word;
      wptr_d         = wptr_q + 1'b1;
    end
    if (take) begin
      pushed_d = pushed_q + 16'd1;
      if (!push) ovf_d = 1'b1;
    end
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          base_d   = i_base_addr;
          num_d    = i_num_vectors;
          shift_d  = i_shift;
          relu_d   = i_relu_en;
          ovf_d    = 1'b0;
          pushed_d = '0;
          idx_d    = '0;
          state_d  = (i_num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (pushed_d == num_q) state_d = (cnt_d == '0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (cnt_d == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      ovf_q      <= 1'b0;
      pushed_q   <= '0;
      idx_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      rq_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      ovf_q      <= ovf_d;
      pushed_q   <= pushed_d;
      idx_q      <= idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      rq_vld_q   <= rq_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

`ifdef REQUANT_STATS_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [16:0] sat_sum;

  always_comb begin
    sat_sum   = {1'b0, sat_cnt_q} + 17'($countones(rq_sat));
    sat_cnt_d = sat_cnt_q;
    if (start_ok)  sat_cnt_d = '0;
    else if (push) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign o_sat_count = sat_cnt_q;
`else
  logic unused_sat;
  assign unused_sat  = ^rq_sat;
  assign o_sat_count = '0;
`endif

  assign o_sram_we    = (cnt_q != '0) && (state_q != IDLE);
  assign o_sram_addr  = base_q + idx_q;
  assign o_sram_wdata = fifo_q[rptr_q];
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_psum_requant_writeback.sv
// Randomized bench for psum_requant_writeback against a queue-based behavioural model.
module tb_psum_requant_writeback;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic [9:0]   i_base_addr = '0;
  logic [15:0]  i_num_vectors = '0;
  logic [4:0]   i_shift = '0;
  logic         i_relu_en = 1'b0;
  logic         i_valid = 1'b0;
  logic [127:0] i_psum_flat = '0;
  logic         i_sram_ready = 1'b0;
  logic         o_sram_we;
  logic [9:0]   o_sram_addr;
  logic [31:0]  o_sram_wdata;
  logic         o_busy, o_done, o_overflow;
  logic [15:0]  o_sat_count;

  always #5 clk = ~clk;

  psum_requant_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_base_addr  (i_base_addr),
    .i_num_vectors(i_num_vectors),
    .i_shift      (i_shift),
    .i_relu_en    (i_relu_en),
    .i_valid      (i_valid),
    .i_psum_flat  (i_psum_flat),
    .i_sram_ready (i_sram_ready),
    .o_sram_we    (o_sram_we),
    .o_sram_addr  (o_sram_addr),
    .o_sram_wdata (o_sram_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overflow   (o_overflow),
    .o_sat_count  (o_sat_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: jobs are described by the spec's rules, the FIFO is a plain queue.
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;
  typedef struct {
    int           due;
    logic [127:0] vec;
  } pend_t;

  pend_t        pend[$];
  logic [31:0]  mfifo[$];
  logic [31:0]  wlog_a[$];
  logic [31:0]  wlog_d[$];
  logic [127:0] slot[4];
  int mstate = S_IDLE, mbase = 0, midx = 0, mnum = 0, mpushed = 0, mshift = 0, msat = 0, cyc = 0;
  bit mrelu = 0, movf = 0;

  function automatic logic [7:0] rq(input logic [31:0] p, input int s, input bit relu,
                                    output bit sat);
    longint r;
    r = longint'($signed(p));
    if (s > 0) r = r + (longint'(1) << (s - 1));
    r = r >>> s;
    sat = 1'b0;
    if (relu && r < 0) return 8'h00;
    if (r > 127) begin sat = 1'b1; return 8'h7F; end
    if (r < -128) begin sat = 1'b1; return 8'h80; end
    return r[7:0];
  endfunction

  function automatic logic [127:0] mkvec(input int a, input int b, input int c, input int d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction

  task automatic step(input bit v, input logic [127:0] vec, input bit st, input bit rdy,
                      input bit r);
    logic [127:0] flat;
    logic [31:0]  w;
    pend_t        p;
    bit           exp_we, pop, s0;
    int           nsat;
    @(negedge clk);
    for (int c = 3; c > 0; c--) slot[c] = slot[c-1];
    slot[0] = v ? vec : {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 4; c++) flat[c*32 +: 32] = slot[c][c*32 +: 32];
    i_psum_flat  = flat;
    i_valid      = v;
    i_start      = st;
    i_sram_ready = rdy;
    rst          = r;
    #1;
    exp_we = (mfifo.size() > 0);
    check("we", {31'd0, o_sram_we}, {31'd0, exp_we});
    check("busy", {31'd0, o_busy}, {31'd0, (mstate == S_RUN || mstate == S_DRAIN)});
    check("done", {31'd0, o_done}, {31'd0, (mstate == S_DONE)});
    check("ovf", {31'd0, o_overflow}, {31'd0, movf});
`ifdef REQUANT_STATS_EN
    check("satcnt", {16'd0, o_sat_count}, msat);
`else
    check("satcnt", {16'd0, o_sat_count}, 32'd0);
`endif
    if (exp_we) begin
      check("addr", {22'd0, o_sram_addr}, (mbase + midx) % 1024);
      check("wdata", o_sram_wdata, mfifo[0]);
    end
    if (o_sram_we && rdy) begin
      wlog_a.push_back({22'd0, o_sram_addr});
      wlog_d.push_back(o_sram_wdata);
    end

    if (r) begin
      pend.delete();
      mfifo.delete();
      mstate = S_IDLE; mbase = 0; midx = 0; mnum = 0; mpushed = 0; mshift = 0; msat = 0;
      mrelu = 0; movf = 0;
    end else begin
      pop = exp_we && rdy;
      if (pop) begin
        void'(mfifo.pop_front());
        midx++;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        if (mstate == S_RUN && mpushed < mnum) begin
          mpushed++;
          if (mfifo.size() < 4) begin
            nsat = 0;
            for (int c = 0; c < 4; c++) begin
              w[c*8 +: 8] = rq(p.vec[c*32 +: 32], mshift, mrelu, s0);
              nsat += int'(s0);
            end
            mfifo.push_back(w);
            msat = (msat + nsat > 65535) ? 65535 : msat + nsat;
          end else begin
            movf = 1'b1;
          end
        end
      end
      if (v && mstate == S_RUN) pend.push_back('{cyc + 4, vec});
      case (mstate)
        S_RUN:   if (mpushed == mnum) mstate = (mfifo.size() == 0) ? S_DONE : S_DRAIN;
        S_DRAIN: if (mfifo.size() == 0) mstate = S_DONE;
        default: begin
          if (st) begin
            mbase = int'(i_base_addr); mnum = int'(i_num_vectors); mshift = int'(i_shift);
            mrelu = i_relu_en; movf = 0; msat = 0; mpushed = 0; midx = 0;
            mstate = (mnum == 0) ? S_DONE : S_RUN;
          end
        end
      endcase
    end
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) step(1'b0, '0, 1'b0, rdy, 1'b0);
  endtask

  task automatic start_job(input int base, input int num, input int sh, input bit relu);
    i_base_addr   = 10'(base);
    i_num_vectors = 16'(num);
    i_shift       = 5'(sh);
    i_relu_en     = relu;
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic send(input logic [127:0] vec, input bit rdy);
    step(1'b1, vec, 1'b0, rdy, 1'b0);
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (!o_done && k < max) begin
      step(1'b0, '0, 1'b0, 1'b1, 1'b0);
      k++;
    end
    check("done_timeout", {31'd0, o_done}, 32'd1);
  endtask

  function automatic logic [127:0] rand_vec();
    logic [127:0] v;
    for (int c = 0; c < 4; c++) begin
      if ($urandom_range(0, 1) == 0) v[c*32 +: 32] = $urandom_range(0, 4000) - 2000;
      else                           v[c*32 +: 32] = $urandom;
    end
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1, k;
    for (int c = 0; c < 4; c++) slot[c] = '0;
    repeat (2) @(posedge clk);
    idle(2, 1'b1);

    // Basic lanes, no shift.
    start_job(10'h010, 1, 0, 1'b0);
    send(mkvec(5, -3, 127, -128), 1'b1);
    wait_done(40);
    check("t1_nwr", wlog_d.size(), 1);
    check("t1_wdata", wlog_d[$], 32'h807FFD05);
    check("t1_addr", wlog_a[$], 32'h010);

    // Rounding shift with saturation, then the same with ReLU.
    start_job(10'h020, 1, 2, 1'b0);
    send(mkvec(1000, -1000, 6, -6), 1'b1);
    wait_done(40);
    check("t2_wdata", wlog_d[$], 32'hFF02807F);
`ifdef REQUANT_STATS_EN
    check("t2_sat", {16'd0, o_sat_count}, 32'd2);
`endif
    start_job(10'h020, 1, 2, 1'b1);
    send(mkvec(1000, -1000, 6, -6), 1'b1);
    wait_done(40);
    check("t2_relu", wlog_d[$], 32'h0002007F);
`ifdef REQUANT_STATS_EN
    check("t2_relu_sat", {16'd0, o_sat_count}, 32'd1);
`endif

    // Address wrap.
    n0 = wlog_a.size();
    start_job(10'h3FE, 3, 1, 1'b0);
    repeat (3) send(rand_vec(), 1'b1);
    wait_done(40);
    check("t3_nwr", wlog_a.size() - n0, 3);
    check("t3_a0", wlog_a[n0], 32'h3FE);
    check("t3_a1", wlog_a[n0+1], 32'h3FF);
    check("t3_a2", wlog_a[n0+2], 32'h000);

    // Backpressure and overflow.
    start_job(10'h100, 6, 0, 1'b0);
    repeat (6) send(rand_vec(), 1'b0);
    idle(8, 1'b0);
    check("t4_ovf", {31'd0, o_overflow}, 32'd1);
    n0 = wlog_a.size();
    wait_done(40);
    check("t4_nwr", wlog_a.size() - n0, 4);

    // Zero-length job, then start ignored while busy.
    n0 = wlog_a.size();
    start_job(10'h055, 0, 0, 1'b0);
    idle(1, 1'b1);
    check("t5_done", {31'd0, o_done}, 32'd1);
    idle(3, 1'b1);
    check("t5_nwr", wlog_a.size() - n0, 0);
    start_job(10'h200, 2, 0, 1'b0);
    send(rand_vec(), 1'b1);
    i_base_addr   = 10'h300;
    i_num_vectors = 16'd9;
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    send(rand_vec(), 1'b1);
    wait_done(40);
    check("t5_addr", wlog_a[$], 32'h201);

    // Reset in the middle of a job.
    start_job(10'h080, 4, 0, 1'b0);
    repeat (4) send(rand_vec(), 1'b1);
    n0 = wlog_a.size();
    k  = 0;
    while (wlog_a.size() == n0 && k < 50) begin
      idle(1, 1'b1);
      k++;
    end
    check("t6_first_wr", {31'd0, wlog_a.size() > n0}, 32'd1);
    idle(2, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n1 = wlog_a.size();
    idle(6, 1'b1);
    check("t6_nwr", wlog_a.size() - n1, 0);
    check("t6_busy", {31'd0, o_busy}, 32'd0);

    // Random jobs with random gaps and backpressure.
    for (int j = 0; j < 20; j++) begin
      start_job($urandom_range(0, 1023), $urandom_range(1, 8), $urandom_range(0, 31),
                1'($urandom_range(0, 1)));
      for (int i = 0; i < int'(i_num_vectors); i++) begin
        idle($urandom_range(0, 2), 1'($urandom_range(0, 3) != 0));
        send(rand_vec(), 1'($urandom_range(0, 3) != 0));
      end
      wait_done(200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
